// File: rtl/axisprbs_check.sv
// -----------------------------------------------------------------------------
// axisprbs_check
//
// AXI-stream sink that checks a pseudorandom LFSR word stream. The checker
// seeds itself from the incoming data, declares lock after LOCK_COUNT correct
// predictions, then counts accepted beats and mismatched beats. UNLOCK_COUNT
// consecutive mismatches while locked drop it back to hunting.
//
// LFSR step, W = C_AXIS_DATA_WIDTH:
//   next(d)[W-2:0] = d[W-1:1]
//   next(d)[W-1]   = ^(d & POLY), POLY = 31'h0000_2001 in the top 31 bits
//
// Ports:
//   S_AXI_ACLK     in   clock
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   S_AXIS_TVALID  in   upstream data valid
//   S_AXIS_TREADY  out  sink ready (0 in reset, otherwise !i_stall)
//   S_AXIS_TDATA   in   upstream data word
//   i_stall        in   1 = hold TREADY low (back-pressure)
//   i_clear        in   synchronous clear of counters and sticky error
//   o_locked       out  1 while locked to the sequence
//   o_err          out  one-cycle pulse after a mismatched beat while locked
//   o_err_sticky   out  set on any locked mismatch, cleared by i_clear
//   o_beat_count   out  beats accepted while locked (saturating)
//   o_err_count    out  mismatched beats while locked (saturating)
// -----------------------------------------------------------------------------
module axisprbs_check #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LOCK_COUNT        = 4,
  parameter int UNLOCK_COUNT      = 8,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         i_stall,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic                         o_err,
  output logic                         o_err_sticky,
  output logic [CNT_WIDTH-1:0]         o_beat_count,
  output logic [CNT_WIDTH-1:0]         o_err_count
);

  localparam int W = C_AXIS_DATA_WIDTH;

  localparam logic [W-1:0] POLY_BASE = W'(31'h0000_2001);
  localparam logic [W-1:0] POLY      = POLY_BASE << (W - 31);

  localparam logic [7:0] LOCK_TARGET   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_TARGET = 8'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Registered state
  logic [0:0]           state_reg,      state_next;
  logic [W-1:0]         expected_reg,   expected_next;
  logic                 seed_valid_reg, seed_valid_next;
  logic [7:0]           run_reg,        run_next;
  logic [CNT_WIDTH-1:0] beat_cnt_reg,   beat_cnt_next;
  logic [CNT_WIDTH-1:0] err_cnt_reg,    err_cnt_next;
  logic                 sticky_reg,     sticky_next;
  logic                 err_reg,        err_next;
  logic                 ready_reg;

  logic         beat;
  logic         data_degenerate;
  logic         data_match;
  logic [W-1:0] data_step;
  logic [W-1:0] exp_step;

  // ready_reg is cleared by reset and set on the first edge after release,
  // so TREADY stays low while in reset and follows !i_stall afterwards.
  assign S_AXIS_TREADY = ready_reg & ~i_stall;
  assign beat          = S_AXIS_TVALID & S_AXIS_TREADY;

  // A word whose top 31 bits are zero would lock the LFSR at zero; never
  // seed from it.
  assign data_degenerate = (S_AXIS_TDATA[W-1 -: 31] == 31'd0);
  assign data_match      = (S_AXIS_TDATA == expected_reg);

  // One LFSR step of the incoming word (used for seeding / hunting) and of
  // the expected word (used for free-running prediction while locked).
  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_shift
      assign data_step[gi] = S_AXIS_TDATA[gi+1];
      assign exp_step[gi]  = expected_reg[gi+1];
    end
  endgenerate
  assign data_step[W-1] = ^(S_AXIS_TDATA & POLY);
  assign exp_step[W-1]  = ^(expected_reg & POLY);

  always_comb begin
    state_next      = state_reg;
    expected_next   = expected_reg;
    seed_valid_next = seed_valid_reg;
    run_next        = run_reg;
    beat_cnt_next   = beat_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    sticky_next     = sticky_reg;
    err_next        = 1'b0;

    if (beat) begin
      if (state_reg == ST_HUNT) begin
        if (seed_valid_reg && data_match) begin
          expected_next = data_step;
          if (run_reg + 8'd1 == LOCK_TARGET) begin
            state_next = ST_LOCKED;
            run_next   = 8'd0;
          end else begin
            run_next = run_reg + 8'd1;
          end
        end else if (!data_degenerate) begin
          // Reseed from this word and restart the match run.
          expected_next   = data_step;
          seed_valid_next = 1'b1;
          run_next        = 8'd0;
        end
      end else begin
        // Locked: prediction runs from our own expected value so a corrupted
        // word does not corrupt the following predictions.
        expected_next = exp_step;
        if (beat_cnt_reg != '1) begin
          beat_cnt_next = beat_cnt_reg + CNT_ONE;
        end
        if (!data_match) begin
          err_next    = 1'b1;
          sticky_next = 1'b1;
          if (err_cnt_reg != '1) begin
            err_cnt_next = err_cnt_reg + CNT_ONE;
          end
          if (run_reg + 8'd1 == UNLOCK_TARGET) begin
            state_next      = ST_HUNT;
            seed_valid_next = 1'b0;
            run_next        = 8'd0;
          end else begin
            run_next = run_reg + 8'd1;
          end
        end else begin
          run_next = 8'd0;
        end
      end
    end

    // Clear has priority over any increment in the same cycle.
    if (i_clear) begin
      beat_cnt_next = '0;
      err_cnt_next  = '0;
      sticky_next   = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg      <= ST_HUNT;
      expected_reg   <= '0;
      seed_valid_reg <= 1'b0;
      run_reg        <= 8'd0;
      beat_cnt_reg   <= '0;
      err_cnt_reg    <= '0;
      sticky_reg     <= 1'b0;
      err_reg        <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      expected_reg   <= expected_next;
      seed_valid_reg <= seed_valid_next;
      run_reg        <= run_next;
      beat_cnt_reg   <= beat_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      sticky_reg     <= sticky_next;
      err_reg        <= err_next;
      ready_reg      <= 1'b1;
    end
  end

  assign o_locked     = (state_reg == ST_LOCKED);
  assign o_err        = err_reg;
  assign o_err_sticky = sticky_reg;
  assign o_beat_count = beat_cnt_reg;
  assign o_err_count  = err_cnt_reg;

endmodule

// File: tb/tb_axisprbs_check.sv
// -----------------------------------------------------------------------------
// tb_axisprbs_check
//
// Self-checking bench for axisprbs_check (W=32, LOCK_COUNT=4, UNLOCK_COUNT=8).
// A behavioural model tracks lock status as "good streak while hunting" and
// "bad streak while locked", with a reference LFSR written as a plain 32-bit
// shift. Directed scenarios plus a randomized valid/stall/clear/bit-flip run.
// -----------------------------------------------------------------------------
module tb_axisprbs_check;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 8;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        stall;
  logic        clear;
  logic        locked;
  logic        err;
  logic        sticky;
  logic [31:0] beat_cnt;
  logic [31:0] err_cnt;

  always #5 clk = ~clk;

  axisprbs_check #(
    .C_AXIS_DATA_WIDTH(32),
    .LOCK_COUNT       (LOCK_N),
    .UNLOCK_COUNT     (UNLOCK_N),
    .CNT_WIDTH        (32)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(aresetn),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA (tdata),
    .i_stall      (stall),
    .i_clear      (clear),
    .o_locked     (locked),
    .o_err        (err),
    .o_err_sticky (sticky),
    .o_beat_count (beat_cnt),
    .o_err_count  (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_locked;
  bit          m_seeded;
  bit          m_sticky;
  bit          m_err;
  logic [31:0] m_pred;
  int          m_good_streak;
  int          m_bad_streak;
  longint      m_beats;
  longint      m_errs;

  logic [31:0] gen;
  longint      base_beats;
  longint      base_errs;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prbs_next(input logic [31:0] d);
    return {d[1] ^ d[14], d[31:1]};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_sticky = 0; m_err = 0;
    m_pred = '0; m_good_streak = 0; m_bad_streak = 0;
    m_beats = 0; m_errs = 0;
  endtask

  task automatic model_cycle(input bit hs, input logic [31:0] d, input bit c);
    m_err = 0;
    if (hs) begin
      if (!m_locked) begin
        if (m_seeded && d == m_pred) begin
          m_good_streak++;
          m_pred = prbs_next(d);
          if (m_good_streak == LOCK_N) begin
            m_locked = 1; m_bad_streak = 0;
          end
        end else if (d[31:1] != 31'd0) begin
          m_seeded = 1; m_good_streak = 0; m_pred = prbs_next(d);
        end
      end else begin
        if (m_beats < 64'hFFFF_FFFF) m_beats++;
        if (d != m_pred) begin
          m_err = 1; m_sticky = 1;
          if (m_errs < 64'hFFFF_FFFF) m_errs++;
          m_bad_streak++;
          if (m_bad_streak == UNLOCK_N) begin
            m_locked = 0; m_seeded = 0; m_good_streak = 0;
          end
        end else begin
          m_bad_streak = 0;
        end
        m_pred = prbs_next(m_pred);
      end
    end
    if (c) begin
      m_beats = 0; m_errs = 0; m_sticky = 0;
    end
  endtask

  // One clock cycle: drive inputs, check TREADY, clock, update model, check.
  task automatic tick(input bit v, input logic [31:0] d, input bit s, input bit c);
    bit hs;
    tvalid = v; tdata = d; stall = s; clear = c;
    #1;
    check("tready", tready, !s);
    hs = v && !s;
    @(posedge clk);
    #1;
    model_cycle(hs, d, c);
    if (hs)
      $display("beat data=%08h locked=%0d err=%0d beats=%0d errs=%0d",
               d, locked, err, beat_cnt, err_cnt);
    check("locked", locked, m_locked);
    check("err", err, m_err);
    check("sticky", sticky, m_sticky);
    check("beat_cnt", beat_cnt, m_beats);
    check("err_cnt", err_cnt, m_errs);
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, gen, 1'b0, 1'b0);
      gen = prbs_next(gen);
    end
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      gen = prbs_next(gen);
    end
  endtask

  initial begin
    aresetn = 1'b0; tvalid = 1'b0; tdata = '0; stall = 1'b0; clear = 1'b0;
    model_reset();
    #3;
    check("rst_tready", tready, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_sticky", sticky, 0);
    check("rst_beats", beat_cnt, 0);
    check("rst_errs", err_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Walking-one seed locks after the fifth beat.
    gen = 32'h8000_0000;
    send_good(4);
    check("no_lock_4", locked, 0);
    send_good(1);
    check("lock_5", locked, 1);
    check("lock_beats", beat_cnt, 0);

    // 100 good, one bit-0 flip, good continuation.
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    send_good(100);
    tick(1'b1, gen ^ 32'h1, 1'b0, 1'b0);
    gen = prbs_next(gen);
    check("flip_err", err, 1);
    check("flip_errs", err_cnt, 1);
    check("flip_beats", beat_cnt, 101);
    check("flip_sticky", sticky, 1);
    send_good(5);
    check("flip_locked", locked, 1);
    check("flip_errs2", err_cnt, 1);

    // Eight all-ones words unlock; a fresh sequence relocks in 5 beats.
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    send_ones(7);
    check("ones7_locked", locked, 1);
    send_ones(1);
    check("ones8_errs", err_cnt, 8);
    check("ones8_unlock", locked, 0);
    gen = $urandom | 32'h8000_0000;
    send_good(4);
    check("relock_4", locked, 0);
    send_good(1);
    check("relock_5", locked, 1);

    // Zero words in HUNT are ignored.
    send_ones(8);
    check("unlock_again", locked, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h0, 1'b0, 1'b0);
    gen = $urandom | 32'h4000_0000;
    send_good(4);
    check("zero_lock_4", locked, 0);
    send_good(1);
    check("zero_lock_5", locked, 1);

    // Stall toggling with TVALID held high.
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, gen, (i % 2) == 1, 1'b0);
      if ((i % 2) == 0) gen = prbs_next(gen);
    end
    check("stall_beats", beat_cnt, 20);
    check("stall_errs", err_cnt, 0);
    check("stall_locked", locked, 1);

    // Randomized valid / stall / clear / bit-flip mix.
    for (int i = 0; i < 400; i++) begin
      bit v, s, c, f;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 14) == 0);
      if (!v) d = $urandom;
      else if (f) d = gen ^ (32'h1 << $urandom_range(0, 31));
      else d = gen;
      tick(v, d, s, c);
      if (v && !s) gen = prbs_next(gen);
    end

    // Clear on the same cycle as an error beat: clear wins.
    send_good(6);
    check("pre_clr_locked", locked, 1);
    tick(1'b1, gen ^ 32'h10, 1'b0, 1'b1);
    gen = prbs_next(gen);
    check("clr_beats", beat_cnt, 0);
    check("clr_errs", err_cnt, 0);
    check("clr_sticky", sticky, 0);

    // Asynchronous reset mid-stream.
    send_good(3);
    tvalid = 1'b1; tdata = gen;
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_tready", tready, 0);
    check("arst_locked", locked, 0);
    check("arst_beats", beat_cnt, 0);
    check("arst_errs", err_cnt, 0);
    check("arst_sticky", sticky, 0);
    model_reset();
    tvalid = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    gen = $urandom | 32'h8000_0000;
    send_good(5);
    check("post_rst_lock", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
